// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the dmem load/store sequencer: access sizes, FSM states,
// registered request payload, response payload and the byte-count helper.
package dmem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NLANES = 4;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    RESP = 2'b11
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } dmem_resp_t;

  // Illegal sizes report 4 so the range check stays conservative.
  function automatic logic [2:0] size_nbytes(input logic [1:0] sz);
    case (size_e'(sz))
      SZ_B:    size_nbytes = 3'd1;
      SZ_H:    size_nbytes = 3'd2;
      default: size_nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Combinational lane steering: byte strobes and shifted store data across two
// words, plus load extraction and sign/zero extension from a {hi,lo} word pair.
module dmem_align
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]        off,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] hi,
  input  logic [DATA_W-1:0] lo,
  output logic [7:0]        be8,
  output logic [63:0]       wd64,
  output logic [DATA_W-1:0] rdata
);

  logic [2:0]        nb;
  logic [7:0]        mask;
  logic [DATA_W-1:0] sh;

  always_comb begin
    nb    = size_nbytes(size);
    mask  = (8'd1 << nb) - 8'd1;
    be8   = mask << off;
    wd64  = {32'd0, wdata} << {off, 3'b000};
    sh    = 32'({hi, lo} >> {off, 3'b000});
    rdata = sh;
    case (size_e'(size))
      SZ_B:    rdata = is_unsigned ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    rdata = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: rdata = sh;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer between the memory stage and dmem; splits word-crossing
// accesses into two aligned word accesses and returns extended load data.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH    = 32,
  parameter  int unsigned DMEM_SZ_IN_KB = 1,
  parameter  int unsigned ADDR_WIDTH    = 32,
  localparam int unsigned WA_W          = $clog2(DMEM_SZ_IN_KB * 1024 / 4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  dmem_en,
  output logic [3:0]            dmem_be,
  output logic [WA_W-1:0]       dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int unsigned DMEM_BYTES = DMEM_SZ_IN_KB * 1024;
  localparam int unsigned EA_W       = ADDR_WIDTH + 1;

  state_e            state, state_nx;
  dmem_req_t         req_q;
  logic [WA_W+1:0]   addr_q;
  logic              err_q;
  logic              split_q;
  logic [DATA_W-1:0] lo_q;

  logic [2:0]        nb_in;
  logic [EA_W-1:0]   end_addr;
  logic              illegal_in;
  logic              split_in;
  logic              accept;
  logic [WA_W-1:0]   word0;
  logic [WA_W-1:0]   word1;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [DATA_W-1:0] al_hi, al_lo, al_rdata;
  dmem_resp_t        resp;

  // Request decode on the input side; only used to pick the first state and to register.
  always_comb begin
    nb_in      = size_nbytes(req_size);
    end_addr   = {1'b0, req_addr} + EA_W'(nb_in) - EA_W'(1);
    illegal_in = (req_size == 2'b11) || (end_addr >= EA_W'(DMEM_BYTES));
    split_in   = ({2'b00, req_addr[1:0]} + {1'b0, nb_in}) > 4'd4;
    accept     = (state == IDLE) && req_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = illegal_in ? RESP : ACC0;
      ACC0:    state_nx = split_q ? ACC1 : RESP;
      ACC1:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Registered request fields and the low word of a split load.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
      split_q <= 1'b0;
      lo_q    <= '0;
    end else begin
      if (accept) begin
        req_q.we          <= req_we;
        req_q.size        <= req_size;
        req_q.is_unsigned <= req_unsigned;
        req_q.wdata       <= req_wdata;
        addr_q            <= req_addr[WA_W+1:0];
        err_q             <= illegal_in;
        split_q           <= split_in;
      end
      if (state == ACC1) lo_q <= dmem_rdata;
    end
  end

  assign word0 = addr_q[WA_W+1:2];
  assign word1 = word0 + WA_W'(1);
  assign al_hi = split_q ? dmem_rdata : '0;
  assign al_lo = split_q ? lo_q : dmem_rdata;

  dmem_align u_align (
    .off         (addr_q[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .wdata       (req_q.wdata),
    .hi          (al_hi),
    .lo          (al_lo),
    .be8         (be8),
    .wd64        (wd64),
    .rdata       (al_rdata)
  );

  // Outputs decode from state only; everything is held at 0 while rst is high.
  always_comb begin
    req_ready  = 1'b0;
    dmem_en    = 1'b0;
    dmem_be    = '0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    resp_valid = 1'b0;
    resp       = '0;
    if (!rst) begin
      case (state)
        IDLE: req_ready = 1'b1;
        ACC0: begin
          dmem_en   = 1'b1;
          dmem_addr = word0;
          if (req_q.we) begin
            dmem_be    = be8[3:0];
            dmem_wdata = wd64[31:0];
          end
        end
        ACC1: begin
          dmem_en   = 1'b1;
          dmem_addr = word1;
          if (req_q.we) begin
            dmem_be    = be8[7:4];
            dmem_wdata = wd64[63:32];
          end
        end
        RESP: begin
          resp_valid = 1'b1;
          resp.err   = err_q;
          resp.rdata = (err_q || req_q.we) ? '0 : al_rdata;
        end
        default: ;
      endcase
    end
  end

  assign resp_err   = resp.err;
  assign resp_rdata = resp.rdata;

endmodule
